// File: rtl/vedic_mac_accumulator.sv
// Multiply-accumulate back end for the Vedic multiplier: sums unsigned products
// into a wide accumulator and emits one result per LEN terms or early on in_last.
module vedic_mac_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN    = 8,
    parameter int unsigned SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [7:0]        out_count,
    output logic              out_ovf
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_close;
    logic               w_release;
    logic [ACC_W:0]     w_full;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ovf_next;

    // Handshake qualifiers; in_ready is held low during reset.
    assign in_ready  = (r_state == S_ACC) && !rst;
    assign out_valid = (r_state == S_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    // One extra bit catches the carry out of the accumulator.
    assign w_full     = {1'b0, r_acc} + (ACC_W+1)'(in_prod);
    assign w_ovf_next = r_ovf | w_full[ACC_W];
    assign w_acc_next = ((SAT != 0) && w_ovf_next) ? '1 : w_full[ACC_W-1:0];
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_close    = w_accept && ((w_cnt_next == LEN_C) || in_last);

    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACC: begin
                if (w_close) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_next = S_ACC;
                end
            end
            default: w_state_next = S_ACC;
        endcase
    end

    // Accumulator and result registers; release and accept never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_release) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (w_close) begin
                r_out_sum   <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_ovf   <= w_ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Bench for vedic_mac_accumulator: a default instance plus a saturating and a
// wrapping 16-bit LEN=2 pair, checked against totals computed from the terms.
module tb_vedic_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_iv, a_il, a_or;
    logic [15:0] a_ip;
    logic        a_ir, a_ov, a_ovf;
    logic [23:0] a_sum;
    logic [7:0]  a_cnt;

    logic        p_iv, p_il, p_or;
    logic [15:0] p_ip;
    logic        s_ir, s_ov, s_ovf, w_ir, w_ov, w_ovf;
    logic [15:0] s_sum, w_sum;
    logic [7:0]  s_cnt, w_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned     tq[$];
    bit              held = 1'b0;
    longint unsigned e_sum_a, e_sum_s, e_sum_w;
    bit              e_ovf_a, e_ovf_p;
    int unsigned     e_cnt;

    always #5 clk = ~clk;

    vedic_mac_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(8), .SAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_prod(a_ip),
        .in_last(a_il), .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum),
        .out_count(a_cnt), .out_ovf(a_ovf)
    );

    vedic_mac_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(2), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(p_iv), .in_ready(s_ir), .in_prod(p_ip),
        .in_last(p_il), .out_valid(s_ov), .out_ready(p_or), .out_sum(s_sum),
        .out_count(s_cnt), .out_ovf(s_ovf)
    );

    vedic_mac_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(2), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(p_iv), .in_ready(w_ir), .in_prod(p_ip),
        .in_last(p_il), .out_valid(w_ov), .out_ready(p_or), .out_sum(w_sum),
        .out_count(w_cnt), .out_ovf(w_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [15:0] d, input logic l);
        if (sel == 0) begin
            a_iv = v; a_ip = d; a_il = l;
        end else begin
            p_iv = v; p_ip = d; p_il = l;
        end
    endtask

    task automatic set_or(input int sel, input logic r);
        if (sel == 0) a_or = r;
        else          p_or = r;
    endtask

    task automatic check_state(input int sel, input string tag, input logic ev, input logic er);
        if (sel == 0) begin
            chk({tag, "_a_out_valid"}, 64'(a_ov), 64'(ev));
            chk({tag, "_a_in_ready"},  64'(a_ir), 64'(er));
        end else begin
            chk({tag, "_s_out_valid"}, 64'(s_ov), 64'(ev));
            chk({tag, "_s_in_ready"},  64'(s_ir), 64'(er));
            chk({tag, "_w_out_valid"}, 64'(w_ov), 64'(ev));
            chk({tag, "_w_in_ready"},  64'(w_ir), 64'(er));
        end
    endtask

    task automatic check_vals(input int sel, input string tag);
        if (sel == 0) begin
            chk({tag, "_a_sum"},   64'(a_sum), e_sum_a);
            chk({tag, "_a_count"}, 64'(a_cnt), 64'(e_cnt));
            chk({tag, "_a_ovf"},   64'(a_ovf), 64'(e_ovf_a));
        end else begin
            chk({tag, "_s_sum"},   64'(s_sum), e_sum_s);
            chk({tag, "_w_sum"},   64'(w_sum), e_sum_w);
            chk({tag, "_s_count"}, 64'(s_cnt), 64'(e_cnt));
            chk({tag, "_w_count"}, 64'(w_cnt), 64'(e_cnt));
            chk({tag, "_s_ovf"},   64'(s_ovf), 64'(e_ovf_p));
            chk({tag, "_w_ovf"},   64'(w_ovf), 64'(e_ovf_p));
        end
    endtask

    // Reference: a result is the plain total of its terms, clipped or reduced mod 2^W.
    task automatic model(input int sel, input int n);
        longint unsigned total = 0;
        longint unsigned lim;
        for (int i = 0; i < n; i++) total += longint'(tq[i]);
        e_cnt = n;
        if (sel == 0) begin
            lim     = 64'd1 << 24;
            e_sum_a = (total >= lim) ? lim - 1 : total;
            e_ovf_a = (total >= lim);
        end else begin
            lim     = 64'd1 << 16;
            e_sum_s = (total >= lim) ? lim - 1 : total;
            e_sum_w = total % lim;
            e_ovf_p = (total >= lim);
        end
    endtask

    task automatic send_terms(input int sel, input int n, input bit last_end, input int gap_pct);
        int start = held ? 1 : 0;
        held = 1'b0;
        for (int i = start; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                check_state(sel, "gap", 1'b0, 1'b1);
                drive(sel, 1'b0, 16'h0000, 1'b0);
            end
            @(negedge clk);
            check_state(sel, "term", 1'b0, 1'b1);
            drive(sel, 1'b1, 16'(tq[i]), last_end && (i == n - 1));
        end
    endtask

    task automatic finish(input int sel, input int n, input int bp, input bit hold,
                          input logic [15:0] hprod);
        model(sel, n);
        @(negedge clk);
        check_state(sel, "close", 1'b1, 1'b0);
        check_vals(sel, "close");
        drive(sel, hold, hprod, 1'b0);
        set_or(sel, bp == 0);
        for (int k = 1; k <= bp; k++) begin
            @(negedge clk);
            check_state(sel, "bp", 1'b1, 1'b0);
            check_vals(sel, "bp");
            if (k == bp) set_or(sel, 1'b1);
        end
        @(negedge clk);
        check_state(sel, "release", 1'b0, 1'b1);
        check_vals(sel, "keep");
        set_or(sel, 1'b0);
        if (hold) held = 1'b1;
        else      drive(sel, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        e_sum_a = 0; e_sum_s = 0; e_sum_w = 0; e_ovf_a = 0; e_ovf_p = 0; e_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            check_state(s, "in_rst", 1'b0, 1'b0);
            check_vals(s, "in_rst");
        end
        rst = 1'b0;
        drive(0, 1'b0, 16'h0000, 1'b0);
        drive(1, 1'b0, 16'h0000, 1'b0);
        set_or(0, 1'b0);
        set_or(1, 1'b0);
        held = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_state(s, "post_rst", 1'b0, 1'b1);
            check_vals(s, "post_rst");
        end
    endtask

    task automatic random_results(input int sel, input int count);
        int          maxn = (sel == 0) ? 8 : 2;
        int          n, nn, bp;
        bit          last_end, hold;
        int unsigned nq[$];
        n = int'($urandom_range(maxn, 1));
        tq.delete();
        for (int i = 0; i < n; i++) tq.push_back($urandom_range(16'hFFFF, 0));
        last_end = (n < maxn) ? 1'b1 : 1'(int'($urandom_range(1)));
        for (int r = 0; r < count; r++) begin
            send_terms(sel, n, last_end, 20);
            hold = (r < count - 1) && ($urandom_range(1) == 1);
            nn   = hold ? int'($urandom_range(maxn, 2)) : int'($urandom_range(maxn, 1));
            nq.delete();
            for (int i = 0; i < nn; i++) nq.push_back($urandom_range(16'hFFFF, 0));
            bp = int'($urandom_range(3));
            finish(sel, n, bp, hold, 16'(nq[0]));
            tq = nq;
            n  = nn;
            last_end = (n < maxn) ? 1'b1 : 1'(int'($urandom_range(1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_iv = 1'b0; a_il = 1'b0; a_or = 1'b0; a_ip = 16'h0000;
        p_iv = 1'b0; p_il = 1'b0; p_or = 1'b0; p_ip = 16'h0000;
        do_reset();

        // Eight full-length terms of 0xFE01.
        tq = '{16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01};
        send_terms(0, 8, 1'b0, 0);
        finish(0, 8, 0, 1'b0, 16'h0000);
        chk("tp_full_sum", 64'(a_sum), 64'h07F008);
        chk("tp_full_cnt", 64'(a_cnt), 64'd8);
        chk("tp_full_ovf", 64'(a_ovf), 64'd0);

        // Early close, then a fresh result starting from zero.
        tq = '{16'h0010, 16'h0020, 16'h0030};
        send_terms(0, 3, 1'b1, 0);
        finish(0, 3, 0, 1'b0, 16'h0000);
        chk("tp_early_sum", 64'(a_sum), 64'h000060);
        chk("tp_early_cnt", 64'(a_cnt), 64'd3);
        tq = '{16'h0005, 16'h0007};
        send_terms(0, 2, 1'b1, 0);
        finish(0, 2, 0, 1'b0, 16'h0000);
        chk("tp_fresh_sum", 64'(a_sum), 64'd12);

        // Overflow on the 16-bit pair, then a clean result.
        tq = '{16'hFE01, 16'hFE01};
        send_terms(1, 2, 1'b0, 0);
        finish(1, 2, 0, 1'b0, 16'h0000);
        chk("tp_sat_sum",  64'(s_sum), 64'hFFFF);
        chk("tp_sat_ovf",  64'(s_ovf), 64'd1);
        chk("tp_wrap_sum", 64'(w_sum), 64'hFC02);
        chk("tp_wrap_ovf", 64'(w_ovf), 64'd1);
        tq = '{16'h0003, 16'h0004};
        send_terms(1, 2, 1'b0, 0);
        finish(1, 2, 0, 1'b0, 16'h0000);
        chk("tp_clean_s_ovf", 64'(s_ovf), 64'd0);
        chk("tp_clean_w_ovf", 64'(w_ovf), 64'd0);
        chk("tp_clean_w_sum", 64'(w_sum), 64'd7);

        // Backpressure with a held next term.
        tq = '{16'h0001, 16'h0002, 16'h0003};
        send_terms(0, 3, 1'b1, 0);
        finish(0, 3, 5, 1'b1, 16'h0ABC);
        tq = '{16'h0ABC, 16'h0100};
        send_terms(0, 2, 1'b1, 0);
        finish(0, 2, 0, 1'b0, 16'h0000);
        chk("tp_held_sum", 64'(a_sum), 64'h000BBC);
        chk("tp_held_cnt", 64'(a_cnt), 64'd2);

        // Input bubbles.
        tq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_terms(0, 8, 1'b0, 40);
        finish(0, 8, 0, 1'b0, 16'h0000);
        chk("tp_gap_sum", 64'(a_sum), 64'd8);

        // Reset mid-accumulation with a term presented in the reset cycle.
        tq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_terms(0, 4, 1'b0, 0);
        do_reset();
        tq = '{16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0002};
        send_terms(0, 8, 1'b0, 0);
        finish(0, 8, 0, 1'b0, 16'h0000);
        chk("tp_rst_sum", 64'(a_sum), 64'h000010);
        chk("tp_rst_cnt", 64'(a_cnt), 64'd8);

        // Reset while a result is pending.
        tq = '{16'h0009};
        send_terms(0, 1, 1'b1, 0);
        do_reset();

        random_results(0, 20);
        random_results(1, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
